// File: rtl/ifm_buf_pkg.sv
// Shared types and sizing helpers for ifm_pingpong_buffer.
// IFM_BUF_PINGPONG_EN selects two banks; without it a single bank is built.
package ifm_buf_pkg;

    typedef logic [0:0] bank_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_BUSY = 1'b1
    } rd_state_e;

`ifdef IFM_BUF_PINGPONG_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

    function automatic int calc_groups(input int depth, input int units);
        return (depth + units - 1) / units;
    endfunction

    function automatic int calc_sel_width(input int depth, input int units);
        return $clog2(depth / units + 1);
    endfunction

    // With a single bank both pointers stay at bank 0.
    function automatic bank_t next_bank(input bank_t b);
        return (NUM_BANKS == 2) ? ~b : bank_t'(0);
    endfunction

endpackage

// File: rtl/ifm_bank_ram.sv
// One unit's slice of one bank: a simple write port and two registered read ports.
// Read outputs hold while their enable is low; out-of-range reads (ok low) return 0.
module ifm_bank_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 150,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_a_i,
    input  logic                  ok_a_i,
    input  logic [IDX_W-1:0]      raddr_a_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    input  logic                  re_b_i,
    input  logic                  ok_b_i,
    input  logic [IDX_W-1:0]      raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_b_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_a_q;
    logic [DATA_WIDTH-1:0] rdata_b_q;

    // Storage is deliberately not reset; contents survive a reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            if (re_a_i) begin
                rdata_a_q <= ok_a_i ? mem_q[raddr_a_i] : '0;
            end
            if (re_b_i) begin
                rdata_b_q <= ok_b_i ? mem_q[raddr_b_i] : '0;
            end
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/ifm_pingpong_buffer.sv
// Feature-map store between pooling and convolution with bank ownership handshakes.
// IFM_BUF_PINGPONG_EN (via ifm_buf_pkg) selects double banking; default is one bank.
module ifm_pingpong_buffer
    import ifm_buf_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int IFM_SIZE         = 5,
    parameter int IFM_DEPTH        = 16,
    parameter int NUMBER_OF_UNITS  = 3,
    parameter int GROUPS           = calc_groups(IFM_DEPTH, NUMBER_OF_UNITS),
    parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int SEL_WIDTH        = calc_sel_width(IFM_DEPTH, NUMBER_OF_UNITS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_from_previous,
    output logic                        end_to_previous,
    input  logic                        ifm_enable_write_current,
    input  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_write_current,
    input  logic [SEL_WIDTH-1:0]        ifm_sel_current,
    input  logic [DATA_WIDTH-1:0]       data_in_1,
    input  logic [DATA_WIDTH-1:0]       data_in_2,
    input  logic [DATA_WIDTH-1:0]       data_in_3,
    output logic                        start_to_next,
    input  logic                        end_from_next,
    input  logic                        ifm_enable_read_A_next,
    input  logic                        ifm_enable_read_B_next,
    input  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_A_next,
    input  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_B_next,
    input  logic [SEL_WIDTH-1:0]        ifm_sel_read_next,
    output logic [DATA_WIDTH-1:0]       data_out_A_unit1,
    output logic [DATA_WIDTH-1:0]       data_out_A_unit2,
    output logic [DATA_WIDTH-1:0]       data_out_A_unit3,
    output logic [DATA_WIDTH-1:0]       data_out_B_unit1,
    output logic [DATA_WIDTH-1:0]       data_out_B_unit2,
    output logic [DATA_WIDTH-1:0]       data_out_B_unit3
);

    localparam int AREA  = IFM_SIZE * IFM_SIZE;
    localparam int DEPTH = GROUPS * AREA;
    localparam int IDX_W = $clog2(DEPTH);

    function automatic logic [IDX_W-1:0] lin_idx(input logic [SEL_WIDTH-1:0] sel,
                                                 input logic [ADDRESS_SIZE_IFM-1:0] addr);
        return IDX_W'(IDX_W'(sel) * IDX_W'(AREA) + IDX_W'(addr));
    endfunction

    function automatic logic in_range(input logic [SEL_WIDTH-1:0] sel,
                                      input logic [ADDRESS_SIZE_IFM-1:0] addr);
        return (int'(sel) < GROUPS) && (int'(addr) < AREA);
    endfunction

    bank_t      wr_bank_q, wr_bank_d;
    bank_t      rd_bank_q, rd_bank_d;
    bank_t      rd_bank_a_q, rd_bank_b_q;
    logic [1:0] full_q, full_d;
    rd_state_e  state_q, state_d;
    logic       start_q, start_d;

    logic [IDX_W-1:0]      widx, ridx_a, ridx_b;
    logic                  wr_ok, rok_a, rok_b;
    logic [DATA_WIDTH-1:0] wdata  [NUMBER_OF_UNITS];
    logic [DATA_WIDTH-1:0] rdata_a [2][NUMBER_OF_UNITS];
    logic [DATA_WIDTH-1:0] rdata_b [2][NUMBER_OF_UNITS];

    assign widx   = lin_idx(ifm_sel_current, ifm_address_write_current);
    assign ridx_a = lin_idx(ifm_sel_read_next, ifm_address_read_A_next);
    assign ridx_b = lin_idx(ifm_sel_read_next, ifm_address_read_B_next);
    assign wr_ok  = ifm_enable_write_current && !full_q[wr_bank_q]
                    && in_range(ifm_sel_current, ifm_address_write_current);
    assign rok_a  = in_range(ifm_sel_read_next, ifm_address_read_A_next);
    assign rok_b  = in_range(ifm_sel_read_next, ifm_address_read_B_next);

    assign wdata[0] = data_in_1;
    assign wdata[1] = data_in_2;
    assign wdata[2] = data_in_3;

    // Writer and reader touch different banks, so both flag updates can land together.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        state_d   = state_q;
        start_d   = 1'b0;
        if (start_from_previous && !full_q[wr_bank_q]) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = next_bank(wr_bank_q);
        end
        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = RD_BUSY;
                    start_d = 1'b1;
                end
            end
            RD_BUSY: begin
                if (end_from_next) begin
                    state_d           = RD_IDLE;
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = next_bank(rd_bank_q);
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank_q   <= '0;
            rd_bank_q   <= '0;
            full_q      <= '0;
            state_q     <= RD_IDLE;
            start_q     <= 1'b0;
            rd_bank_a_q <= '0;
            rd_bank_b_q <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            state_q   <= state_d;
            start_q   <= start_d;
            // Remember which bank each port last read so held data stays put across a swap.
            if (ifm_enable_read_A_next) rd_bank_a_q <= rd_bank_q;
            if (ifm_enable_read_B_next) rd_bank_b_q <= rd_bank_q;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        if (b < NUM_BANKS) begin : g_used
            for (genvar u = 0; u < NUMBER_OF_UNITS; u++) begin : g_unit
                ifm_bank_ram #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .DEPTH      (DEPTH),
                    .IDX_W      (IDX_W)
                ) u_ram (
                    .clk_i     (clk),
                    .rst_ni    (reset),
                    .we_i      (wr_ok && (wr_bank_q == bank_t'(b))),
                    .waddr_i   (widx),
                    .wdata_i   (wdata[u]),
                    .re_a_i    (ifm_enable_read_A_next && (rd_bank_q == bank_t'(b))),
                    .ok_a_i    (rok_a),
                    .raddr_a_i (ridx_a),
                    .rdata_a_o (rdata_a[b][u]),
                    .re_b_i    (ifm_enable_read_B_next && (rd_bank_q == bank_t'(b))),
                    .ok_b_i    (rok_b),
                    .raddr_b_i (ridx_b),
                    .rdata_b_o (rdata_b[b][u])
                );
            end
        end else begin : g_absent
            for (genvar u = 0; u < NUMBER_OF_UNITS; u++) begin : g_unit
                assign rdata_a[b][u] = '0;
                assign rdata_b[b][u] = '0;
            end
        end
    end

    assign end_to_previous  = !full_q[wr_bank_q];
    assign start_to_next    = start_q;
    assign data_out_A_unit1 = rdata_a[rd_bank_a_q][0];
    assign data_out_A_unit2 = rdata_a[rd_bank_a_q][1];
    assign data_out_A_unit3 = rdata_a[rd_bank_a_q][2];
    assign data_out_B_unit1 = rdata_b[rd_bank_b_q][0];
    assign data_out_B_unit2 = rdata_b[rd_bank_b_q][1];
    assign data_out_B_unit3 = rdata_b[rd_bank_b_q][2];

endmodule

// File: tb/tb_ifm_pingpong_buffer.sv
// Directed bench for ifm_pingpong_buffer with a bank-count model; IFM_BUF_PINGPONG_EN picks 1 or 2 banks.
module tb_ifm_pingpong_buffer;

    localparam int DW     = 32;
    localparam int SZ     = 5;
    localparam int DEP    = 16;
    localparam int NU     = 3;
    localparam int GR     = (DEP + NU - 1) / NU;
    localparam int AW     = $clog2(SZ * SZ);
    localparam int SW     = $clog2(DEP / NU + 1);
    localparam int AREA   = SZ * SZ;
    localparam int MDEPTH = GR * AREA;
`ifdef IFM_BUF_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sfp = 1'b0, efn = 1'b0;
    logic          wen = 1'b0, ren_a = 1'b0, ren_b = 1'b0;
    logic [AW-1:0] waddr = '0, raddr_a = '0, raddr_b = '0;
    logic [SW-1:0] wsel = '0, rsel = '0;
    logic [DW-1:0] din [NU];
    logic          end_to_previous, start_to_next;
    logic [DW-1:0] oa1, oa2, oa3, ob1, ob2, ob3;
    logic [DW-1:0] oa [NU];
    logic [DW-1:0] ob [NU];

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    assign oa[0] = oa1;
    assign oa[1] = oa2;
    assign oa[2] = oa3;
    assign ob[0] = ob1;
    assign ob[1] = ob2;
    assign ob[2] = ob3;

    always #5 clk = ~clk;

    ifm_pingpong_buffer #(
        .DATA_WIDTH      (DW),
        .IFM_SIZE        (SZ),
        .IFM_DEPTH       (DEP),
        .NUMBER_OF_UNITS (NU)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .start_from_previous       (sfp),
        .end_to_previous           (end_to_previous),
        .ifm_enable_write_current  (wen),
        .ifm_address_write_current (waddr),
        .ifm_sel_current           (wsel),
        .data_in_1                 (din[0]),
        .data_in_2                 (din[1]),
        .data_in_3                 (din[2]),
        .start_to_next             (start_to_next),
        .end_from_next             (efn),
        .ifm_enable_read_A_next    (ren_a),
        .ifm_enable_read_B_next    (ren_b),
        .ifm_address_read_A_next   (raddr_a),
        .ifm_address_read_B_next   (raddr_b),
        .ifm_sel_read_next         (rsel),
        .data_out_A_unit1          (oa1),
        .data_out_A_unit2          (oa2),
        .data_out_A_unit3          (oa3),
        .data_out_B_unit1          (ob1),
        .data_out_B_unit2          (ob2),
        .data_out_B_unit3          (ob3)
    );

    // Model: banks are filled and drained in round-robin order, so a fill count plus
    // two ring pointers captures ownership; memory is a plain array with known flags.
    logic [DW-1:0] m_mem   [2][NU][MDEPTH];
    bit            m_known [2][NU][MDEPTH];
    int            m_cnt = 0, m_wptr = 0, m_rptr = 0, m_next = 0;
    bit            m_busy = 1'b0;
    logic [DW-1:0] exp_a [NU];
    logic [DW-1:0] exp_b [NU];
    bit            kn_a [NU];
    bit            kn_b [NU];
    logic          exp_start = 1'b0, exp_endp = 1'b1;

    function automatic bit ok(input int sel, input int addr);
        return (sel < GR) && (addr < AREA);
    endfunction

    task automatic model_read(input int sel, input int addr, output logic [DW-1:0] v[NU], output bit k[NU]);
        for (int u = 0; u < NU; u++) begin
            if (ok(sel, addr)) begin
                v[u] = m_mem[m_rptr][u][sel * AREA + addr];
                k[u] = m_known[m_rptr][u][sel * AREA + addr];
            end else begin
                v[u] = '0;
                k[u] = 1'b1;
            end
        end
    endtask

    task automatic model_step();
        if (!reset) begin
            m_cnt = 0; m_wptr = 0; m_rptr = 0; m_busy = 1'b0;
            exp_start = 1'b0; exp_endp = 1'b1;
            for (int u = 0; u < NU; u++) begin
                exp_a[u] = '0; exp_b[u] = '0; kn_a[u] = 1'b1; kn_b[u] = 1'b1;
            end
        end else begin
            if (ren_a) model_read(int'(rsel), int'(raddr_a), exp_a, kn_a);
            if (ren_b) model_read(int'(rsel), int'(raddr_b), exp_b, kn_b);
            if (wen && m_cnt < NB && ok(int'(wsel), int'(waddr))) begin
                for (int u = 0; u < NU; u++) begin
                    m_mem[m_wptr][u][int'(wsel) * AREA + int'(waddr)]   = din[u];
                    m_known[m_wptr][u][int'(wsel) * AREA + int'(waddr)] = 1'b1;
                end
            end
            m_next    = m_cnt;
            exp_start = 1'b0;
            if (sfp && m_cnt < NB) begin
                m_next = m_next + 1;
                m_wptr = (m_wptr + 1) % NB;
            end
            if (m_busy) begin
                if (efn) begin
                    m_next = m_next - 1;
                    m_rptr = (m_rptr + 1) % NB;
                    m_busy = 1'b0;
                end
            end else if (m_cnt > 0) begin
                m_busy    = 1'b1;
                exp_start = 1'b1;
            end
            m_cnt    = m_next;
            exp_endp = (m_cnt < NB);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("end_to_previous", 32'(end_to_previous), 32'(exp_endp));
            check("start_to_next", 32'(start_to_next), 32'(exp_start));
            for (int u = 0; u < NU; u++) begin
                if (kn_a[u]) check($sformatf("data_out_A_unit%0d", u + 1), oa[u], exp_a[u]);
                if (kn_b[u]) check($sformatf("data_out_B_unit%0d", u + 1), ob[u], exp_b[u]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic fill_bank(input int base);
        for (int i = 0; i < MDEPTH; i++) begin
            wen    = 1'b1;
            wsel   = SW'(i / AREA);
            waddr  = AW'(i % AREA);
            din[0] = DW'(i + base);
            din[1] = DW'(i + base + 1000);
            din[2] = DW'(i + base + 2000);
            tick();
        end
        wen = 1'b0;
    endtask

    task automatic write_one(input int sel, input int addr, input int val);
        wen = 1'b1; wsel = SW'(sel); waddr = AW'(addr);
        din[0] = DW'(val); din[1] = DW'(val); din[2] = DW'(val);
        tick();
        wen = 1'b0;
    endtask

    task automatic pulse_start();
        sfp = 1'b1; tick(); sfp = 1'b0;
    endtask

    task automatic pulse_end();
        efn = 1'b1; tick(); efn = 1'b0;
    endtask

    task automatic rd(input int sel, input int addr_a, input int addr_b);
        ren_a = 1'b1; ren_b = 1'b1; rsel = SW'(sel);
        raddr_a = AW'(addr_a); raddr_b = AW'(addr_b);
        tick();
        ren_a = 1'b0; ren_b = 1'b0;
    endtask

    task automatic start_timing(input string tag);
        at_neg();
        check({tag, "_start_early"}, 32'(start_to_next), 32'(0));
        at_neg();
        check({tag, "_start_rise"}, 32'(start_to_next), 32'(1));
        at_neg();
        check({tag, "_start_len"}, 32'(start_to_next), 32'(0));
    endtask

    initial begin
        for (int u = 0; u < NU; u++) din[u] = '0;
        #2 reset = 1'b0;
        cmp_en = 1'b1;
        repeat (3) tick();
        at_neg();
        check("rst_end_to_previous", 32'(end_to_previous), 32'(1));
        check("rst_start_to_next", 32'(start_to_next), 32'(0));
        check("rst_data_A1", oa1, 32'(0));
        check("rst_data_B3", ob3, 32'(0));
        tick();
        reset = 1'b1;
        tick();

        // Fill and read
        fill_bank(100);
        pulse_start();
        start_timing("fill1");
        rd(2, 7, 0);
        at_neg();
        check("read_A1_sel2_addr7", oa1, 32'(157));
        check("read_A3_sel2_addr7", oa3, 32'(2157));
        check("read_B1_sel2_addr0", ob1, 32'(150));
        repeat (2) tick();
        at_neg();
        check("hold_A1", oa1, 32'(157));

        // Double fill without release; later writes must not land
        fill_bank(500);
        pulse_start();
        fill_bank(900);
        repeat (3) tick();
        rd(2, 7, 3);
        at_neg();
        check("both_full_end_to_previous", 32'(end_to_previous), 32'(0));
        check("old_data_A1", oa1, 32'(157));

        // Release
        pulse_end();
        at_neg();
        check("release_end_to_previous", 32'(end_to_previous), 32'(1));
        repeat (4) tick();
        rd(1, 3, 4);
        repeat (2) tick();

        // Start and end in the same cycle
        fill_bank(700);
        sfp = 1'b1; efn = 1'b1;
        tick();
        sfp = 1'b0; efn = 1'b0;
        repeat (4) tick();
        rd(4, 9, 24);
        pulse_end();
        repeat (4) tick();

        // Range checks and end in IDLE
        write_one(6, 0, 32'hDEAD);
        write_one(0, 25, 32'hBEEF);
        rd(6, 0, 0);
        at_neg();
        check("sel6_read_A1", oa1, 32'(0));
        check("sel6_read_B2", ob2, 32'(0));
        rd(1, 0, 31);
        pulse_end();
        repeat (4) tick();
        at_neg();
        check("idle_end_no_start", 32'(start_to_next), 32'(0));

        // Reset while the reader is busy
        fill_bank(300);
        pulse_start();
        repeat (3) tick();
        rd(2, 7, 1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("midrst_end_to_previous", 32'(end_to_previous), 32'(1));
        check("midrst_start_to_next", 32'(start_to_next), 32'(0));
        check("midrst_data_A1", oa1, 32'(0));
        check("midrst_data_B2", ob2, 32'(0));
        tick();
        tick();
        reset = 1'b1;
        tick();
        fill_bank(100);
        pulse_start();
        start_timing("refill");
        rd(2, 7, 0);
        at_neg();
        check("refill_read_A1", oa1, 32'(157));
        repeat (2) tick();

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
